mul_unit: RTL and testbench

Sequential 32-bit multiplier in the execute stage of the CPU. It takes the same two register operands that feed the ALU and produces a 64-bit product over 32 cycles using shift-add. Control stalls the pipeline while `busy_o` is high. The low product word is then muxed with the ALU result onto the write-back path. This replaces the single-cycle combinational multiply (ALU control code 3'b011) with a bounded-area iterative unit.

---
 rtl/mul_unit_pkg.sv | 15 +
 rtl/mul_unit.sv | 108 ++++++++++
 tb/tb_mul_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_pkg.sv
// Shared CPU definitions used by the iterative multiplier and the control
// logic that steers ALU operands into it.
package mul_unit_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] ALU_CTRL_MUL = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_unit.sv
// Shift-add multiplier for the execute stage: one WIDTH x WIDTH product
// every WIDTH+1 cycles, signed or unsigned, with a registered 2*WIDTH result.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int WIDTH = mul_unit_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             Zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] addend, acc_sum;

  // The datapath works on magnitudes; the sign is reapplied once at the end.
  assign mag1 = (signed_i && data1_i[WIDTH-1]) ? -data1_i : data1_i;
  assign mag2 = (signed_i && data2_i[WIDTH-1]) ? -data2_i : data2_i;

  assign addend  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          mcand_d  = mag1;
          mplier_d = mag2;
          neg_d    = signed_i & (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
          acc_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          prod_d  = neg_q ? -acc_sum : acc_sum;
          zero_d  = (prod_d[WIDTH-1:0] == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      prod_q   <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      zero_q   <= zero_d;
    end
  end

  assign data_o = prod_q[WIDTH-1:0];
  assign hi_o   = prod_q[2*WIDTH-1:WIDTH];
  assign Zero_o = zero_q;
  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: reset, signed/unsigned products, latency,
// ignored start during RUN, back-to-back start from DONE and reset abort.
module tb_mul_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [31:0] data_o;
  logic [31:0] hi_o;
  logic        Zero_o;
  logic        busy_o;
  logic        done_o;

  int assert_count = 0;
  int fail_count   = 0;

  mul_unit #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .signed_i(signed_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .data_o  (data_o),
    .hi_o    (hi_o),
    .Zero_o  (Zero_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one request and waits (bounded) for done_o; leaves the bench at
  // the negedge of the DONE cycle with start_i low.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output int lat, output int busy_cnt);
    @(negedge clk_i);
    start_i  = 1'b1;
    signed_i = s;
    data1_i  = a;
    data2_i  = b;
    @(negedge clk_i);
    start_i  = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    assert_count++;
    if (data_o !== 32'h0) begin
      fail_count++; $display("[TB] FAIL reset_data_o got %h want 00000000", data_o);
    end
    assert_count++;
    if (hi_o !== 32'h0) begin
      fail_count++; $display("[TB] FAIL reset_hi_o got %h want 00000000", hi_o);
    end
    assert_count++;
    if (Zero_o !== 1'b1) begin
      fail_count++; $display("[TB] FAIL reset_zero got %b want 1", Zero_o);
    end
    assert_count++;
    if (busy_o !== 1'b0) begin
      fail_count++; $display("[TB] FAIL reset_busy got %b want 0", busy_o);
    end
    assert_count++;
    if (done_o !== 1'b0) begin
      fail_count++; $display("[TB] FAIL reset_done got %b want 0", done_o);
    end
  endtask

  task automatic test_unsigned_max();
    int lat, busy_cnt;
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, busy_cnt);
    assert_count++;
    if (hi_o !== 32'hFFFFFFFE) begin
      fail_count++; $display("[TB] FAIL umax_hi got %h want fffffffe", hi_o);
    end
    assert_count++;
    if (data_o !== 32'h00000001) begin
      fail_count++; $display("[TB] FAIL umax_lo got %h want 00000001", data_o);
    end
    assert_count++;
    if (Zero_o !== 1'b0) begin
      fail_count++; $display("[TB] FAIL umax_zero got %b want 0", Zero_o);
    end
    assert_count++;
    if (lat !== 32) begin
      fail_count++; $display("[TB] FAIL umax_latency got %0d want 32", lat);
    end
    assert_count++;
    if (busy_cnt !== 32) begin
      fail_count++; $display("[TB] FAIL umax_busy_cycles got %0d want 32", busy_cnt);
    end
  endtask

  task automatic test_signed_mixed();
    int lat, busy_cnt;
    run_mul(32'hFFFFFFFD, 32'h00000007, 1'b1, lat, busy_cnt);
    assert_count++;
    if ({hi_o, data_o} !== 64'hFFFFFFFF_FFFFFFEB) begin
      fail_count++; $display("[TB] FAIL signed_m3x7 got %h_%h want ffffffff_ffffffeb", hi_o, data_o);
    end
    assert_count++;
    if (done_o !== 1'b1 || lat !== 32) begin
      fail_count++; $display("[TB] FAIL signed_m3x7_latency got %0d want 32", lat);
    end
    run_mul(32'hFFFFFFFD, 32'h00000007, 1'b0, lat, busy_cnt);
    assert_count++;
    if ({hi_o, data_o} !== 64'h00000006_FFFFFFEB) begin
      fail_count++; $display("[TB] FAIL unsigned_fffffffdx7 got %h_%h want 00000006_ffffffeb", hi_o, data_o);
    end
  endtask

  task automatic test_signed_min();
    int lat, busy_cnt;
    run_mul(32'h80000000, 32'h80000000, 1'b1, lat, busy_cnt);
    assert_count++;
    if (hi_o !== 32'h40000000) begin
      fail_count++; $display("[TB] FAIL smin_hi got %h want 40000000", hi_o);
    end
    assert_count++;
    if (data_o !== 32'h0) begin
      fail_count++; $display("[TB] FAIL smin_lo got %h want 00000000", data_o);
    end
    assert_count++;
    if (Zero_o !== 1'b1) begin
      fail_count++; $display("[TB] FAIL smin_zero got %b want 1", Zero_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] held_lo;
    held_lo = data_o;
    @(negedge clk_i);
    start_i  = 1'b1;
    signed_i = 1'b0;
    data1_i  = 32'd5;
    data2_i  = 32'd6;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 100) begin
      if (lat == 10) begin
        start_i = 1'b1;
        data1_i = 32'd9;
        data2_i = 32'd9;
        assert_count++;
        if (data_o !== held_lo) begin
          fail_count++; $display("[TB] FAIL hold_during_run got %h want %h", data_o, held_lo);
        end
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    assert_count++;
    if (lat !== 32) begin
      fail_count++; $display("[TB] FAIL ignore_latency got %0d want 32", lat);
    end
    assert_count++;
    if ({hi_o, data_o} !== 64'd30) begin
      fail_count++; $display("[TB] FAIL ignore_result got %h_%h want 0_1e", hi_o, data_o);
    end
    start_i = 1'b1;
    data1_i = 32'd9;
    data2_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    assert_count++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      fail_count++; $display("[TB] FAIL b2b_busy got busy=%b done=%b want busy=1 done=0", busy_o, done_o);
    end
    lat = 0;
    while (!done_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    assert_count++;
    if (lat !== 32) begin
      fail_count++; $display("[TB] FAIL b2b_latency got %0d want 32", lat);
    end
    assert_count++;
    if ({hi_o, data_o} !== 64'd81) begin
      fail_count++; $display("[TB] FAIL b2b_result got %h_%h want 0_51", hi_o, data_o);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    @(negedge clk_i);
    start_i  = 1'b1;
    signed_i = 1'b0;
    data1_i  = 32'h1234;
    data2_i  = 32'h10;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    assert_count++;
    if (data_o !== 32'h0 || hi_o !== 32'h0) begin
      fail_count++; $display("[TB] FAIL abort_product got %h_%h want 0_0", hi_o, data_o);
    end
    assert_count++;
    if (Zero_o !== 1'b1) begin
      fail_count++; $display("[TB] FAIL abort_zero got %b want 1", Zero_o);
    end
    assert_count++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      fail_count++; $display("[TB] FAIL abort_flags got busy=%b done=%b want 0 0", busy_o, done_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) done_seen++;
    end
    assert_count++;
    if (done_seen !== 0) begin
      fail_count++; $display("[TB] FAIL abort_no_done got %0d active cycles want 0", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_mixed();
    test_signed_min();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
